fp32_to_fp16_conv: RTL and testbench
====================================

Name: fp32_to_fp16_conv

Overview:
- Streaming down-converter from IEEE-754 binary32 to binary16, used on the tensor-core writeback path.
- The fp16×fp16→fp32 product/accumulate results are narrowed back to fp16 here before storage.
- 2-stage pipeline with valid/ready handshake on both sides.
- Round-to-nearest-even (RNE) with full special-case, overflow and subnormal handling, plus sticky-free per-result exception flags.

Parameters:
- NAN_PAYLOAD, 16'h7E00, canonical quiet-NaN pattern without sign; output sign is taken from the input.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  converter can accept in_data this cycle
- in_data  in  32  fp32 operand
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts out_data this cycle
- out_data  out  16  fp16 result
- out_overflow  out  1  finite input rounded to ±inf
- out_underflow  out  1  result tiny (below 2^-14 before rounding) AND inexact
- out_inexact  out  1  result differs from input value

Behaviour:
- Reset: the one clock is clk; rst_n is asynchronous and active-low. While rst_n=0, s1_valid=0 and out_valid=0; out_data and all flags are 0. in_ready becomes 1 on the first cycle after release.
- Reset mid-operation discards all in-flight words; nothing is emitted afterwards for them.
- Enables:
  - en2 = ~out_valid | out_ready
  - en1 = ~s1_valid | en2
  - in_ready = en1, combinational, with no dependence on in_valid.
  - A transfer occurs when valid & ready on a side.
- Latency and throughput: an accepted word appears on out_* two cycles later if there is no stall, at 1 word/cycle sustained. Order is preserved, with no drop and no duplication.
- Stall: while out_valid & ~out_ready, out_data and all flags hold stable. Stage 1 holds if full. in_ready=0 only when both stages are full and out_ready=0.
- Stage 1 (unpack and classify):
  - Fields: s = in[31], E = in[30:23], M = in[22:0]; sig = {1,M}, 24 bits.
  - e16 = E − 112, 9-bit signed.
  - Class: NaN (E=255, M≠0), INF (E=255, M=0), ZERO (E=0, covering fp32 zero and fp32 subnormals), OVF (e16≥31), NORM (1≤e16≤30), SUB (e16≤0).
  - shift = 1 − e16 for SUB, clamped to 26; 0 otherwise. Register s, class, e16[4:0], sig, shift.
- Stage 2 (round and pack):
  - NORM: frac = sig[22:13], guard = sig[12], sticky = |sig[11:0], base = {e16[4:0], frac}.
  - SUB: t = sig >> (13+shift), frac = t[9:0], guard = bit (12+shift) of sig, sticky = OR of bits below it, base = {5'b0, frac}.
  - round_up = guard & (sticky | frac[0]). mag = base + round_up, a 15-bit add.
  - Carry propagates naturally: subnormal 0x3FF+1 becomes min normal 0x0400; 0x7BFF+1 becomes inf 0x7C00.
  - inexact = guard | sticky. overflow = (mag == 15'h7C00) for a NORM source. underflow = SUB & inexact.
  - out_data = {s, mag}.
- Special classes:
  - NaN: {s, NAN_PAYLOAD[14:0]}, no flags.
  - INF: {s, 15'h7C00}, no flags.
  - ZERO: {s, 15'h0}; if M≠0, inexact=1 and underflow=1.
  - OVF: {s, 15'h7C00}, overflow=1, inexact=1.
- Shift ≥ 12: guard=0 and the result is signed zero with inexact and underflow set. Shift = 11: the result is 0x0001 iff sticky, otherwise zero.

Test Plan:
- Basic conversions, reset then one word each with out_ready=1:
  - 0x3F800000 → 0x3C00 exactly 2 cycles after acceptance, flags 0.
  - 0xC0490FDB (−π) → 0xC248, inexact=1.
- Upper boundary:
  - 0x477FE000 → 0x7BFF, no flags.
  - 0x477FF000 (tie, odd LSB) → 0x7C00, overflow=1, inexact=1.
  - 0x7F000000 → 0x7C00, overflow=1.
- Subnormal boundary:
  - 0x33800000 → 0x0001, exact.
  - 0x33000000 (tie to even) → 0x0000, underflow=1, inexact=1.
  - 0x387FE000 → 0x0400 via rounding carry, inexact=1, underflow=1.
- Specials:
  - 0xFFC00001 → 0xFE00.
  - 0xFF800000 → 0xFC00.
  - 0x80000000 → 0x8000.
  - 0x00000001 → 0x0000, underflow=1.
- Backpressure: stream 6 words back-to-back, out_ready=0 for cycles 3–6.
  - in_ready drops once 2 words are held.
  - out_data stays stable while stalled.
  - All 6 results emerge in order with none lost.
- Async reset mid-stream: assert rst_n=0 between clock edges with 2 words in flight → out_valid=0 immediately; no stale word appears after release.

Source files
------------

// File: rtl/fp32_to_fp16_conv.sv
// Two-stage streaming fp32 -> fp16 narrowing converter with RNE rounding and
// per-result overflow/underflow/inexact flags; valid/ready on both sides.
module fp32_to_fp16_conv #(
    parameter logic [15:0] NAN_PAYLOAD = 16'h7E00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_overflow,
    output logic        out_underflow,
    output logic        out_inexact
);

    localparam logic [2:0] CLS_NORM = 3'd0;
    localparam logic [2:0] CLS_SUB  = 3'd1;
    localparam logic [2:0] CLS_ZERO = 3'd2;
    localparam logic [2:0] CLS_OVF  = 3'd3;
    localparam logic [2:0] CLS_INF  = 3'd4;
    localparam logic [2:0] CLS_NAN  = 3'd5;

    logic        en1;
    logic        en2;

    logic        s1_valid_reg;
    logic        s1_sign_reg;
    logic [2:0]  s1_cls_reg;
    logic [4:0]  s1_e16_reg;
    logic [23:0] s1_sig_reg;
    logic [4:0]  s1_shift_reg;

    logic        out_valid_reg;
    logic [15:0] out_data_reg;
    logic        out_overflow_reg;
    logic        out_underflow_reg;
    logic        out_inexact_reg;

    assign en2      = ~out_valid_reg | out_ready;
    assign en1      = ~s1_valid_reg | en2;
    assign in_ready = en1;

    // ---------------- stage 1: unpack and classify ----------------
    logic              in_sign;
    logic [7:0]        in_exp;
    logic [22:0]       in_man;
    logic signed [8:0] in_e16;
    logic signed [8:0] sub_amt;
    logic [2:0]        cls_next;
    logic [4:0]        shift_next;

    assign in_sign = in_data[31];
    assign in_exp  = in_data[30:23];
    assign in_man  = in_data[22:0];
    assign in_e16  = $signed({1'b0, in_exp}) - 9'sd112;
    assign sub_amt = 9'sd1 - in_e16;

    always_comb begin
        cls_next   = CLS_NORM;
        shift_next = 5'd0;
        if (in_exp == 8'hFF) begin
            cls_next = (in_man != 23'd0) ? CLS_NAN : CLS_INF;
        end else if (in_exp == 8'h00) begin
            // fp32 subnormals are far below the fp16 range and flush to zero
            cls_next = CLS_ZERO;
        end else if (in_e16 >= 9'sd31) begin
            cls_next = CLS_OVF;
        end else if (in_e16 >= 9'sd1) begin
            cls_next = CLS_NORM;
        end else begin
            cls_next   = CLS_SUB;
            shift_next = (sub_amt > 9'sd26) ? 5'd26 : sub_amt[4:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_sign_reg  <= 1'b0;
            s1_cls_reg   <= CLS_ZERO;
            s1_e16_reg   <= 5'd0;
            s1_sig_reg   <= 24'd0;
            s1_shift_reg <= 5'd0;
        end else if (en1) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_sign_reg  <= in_sign;
                s1_cls_reg   <= cls_next;
                s1_e16_reg   <= in_e16[4:0];
                s1_sig_reg   <= {1'b1, in_man};
                s1_shift_reg <= shift_next;
            end
        end
    end

    // ---------------- stage 2: round and pack ----------------
    // Significand is placed so that bits [48:39] are the kept fraction, bit 38
    // the guard and the rest sticky; shift=0 gives the normal-number split.
    logic [48:0] aligned;
    logic [9:0]  frac;
    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [14:0] base;
    logic [14:0] mag;
    logic [14:0] res_mag;
    logic        res_ovf;
    logic        res_unf;
    logic        res_inx;

    assign aligned  = 49'({s1_sig_reg, 26'd0} >> s1_shift_reg);
    assign frac     = aligned[48:39];
    assign guard    = aligned[38];
    assign sticky   = |aligned[37:0];
    assign round_up = guard & (sticky | frac[0]);
    assign base     = (s1_cls_reg == CLS_SUB) ? {5'd0, frac} : {s1_e16_reg, frac};
    assign mag      = base + {14'd0, round_up};

    always_comb begin
        res_mag = mag;
        res_ovf = 1'b0;
        res_unf = 1'b0;
        res_inx = 1'b0;
        case (s1_cls_reg)
            CLS_NAN: res_mag = NAN_PAYLOAD[14:0];
            CLS_INF: res_mag = 15'h7C00;
            CLS_ZERO: begin
                res_mag = 15'd0;
                res_inx = |s1_sig_reg[22:0];
                res_unf = |s1_sig_reg[22:0];
            end
            CLS_OVF: begin
                res_mag = 15'h7C00;
                res_ovf = 1'b1;
                res_inx = 1'b1;
            end
            CLS_SUB: begin
                res_inx = guard | sticky;
                res_unf = guard | sticky;
            end
            default: begin
                res_inx = guard | sticky;
                res_ovf = (mag == 15'h7C00);
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg     <= 1'b0;
            out_data_reg      <= 16'd0;
            out_overflow_reg  <= 1'b0;
            out_underflow_reg <= 1'b0;
            out_inexact_reg   <= 1'b0;
        end else if (en2) begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                out_data_reg      <= {s1_sign_reg, res_mag};
                out_overflow_reg  <= res_ovf;
                out_underflow_reg <= res_unf;
                out_inexact_reg   <= res_inx;
            end
        end
    end

    assign out_valid     = out_valid_reg;
    assign out_data      = out_data_reg;
    assign out_overflow  = out_overflow_reg;
    assign out_underflow = out_underflow_reg;
    assign out_inexact   = out_inexact_reg;

endmodule

// File: tb/tb_fp32_to_fp16_conv.sv
// Self-checking bench for fp32_to_fp16_conv: directed corner cases, backpressure,
// randomized streaming against a real-arithmetic reference, and async reset.
module tb_fp32_to_fp16_conv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_overflow;
    logic        out_underflow;
    logic        out_inexact;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fp32_to_fp16_conv dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_overflow (out_overflow),
        .out_underflow(out_underflow),
        .out_inexact  (out_inexact)
    );

    function automatic real pow2(input int n);
        real p;
        p = 1.0;
        if (n >= 0) for (int i = 0; i < n; i++) p = p * 2.0;
        else        for (int i = 0; i < -n; i++) p = p / 2.0;
        return p;
    endfunction

    // Reference: exact real value of the fp32 input, rounded to fp16 with RNE.
    // Result packing is {overflow, underflow, inexact, fp16}.
    function automatic logic [18:0] ref_conv(input logic [31:0] x);
        logic        sgn;
        int          ex, mn, f, e;
        real         v, q, r;
        logic [14:0] mag;
        logic        ovf, unf, inx;
        sgn = x[31];
        ex  = int'(x[30:23]);
        mn  = int'(x[22:0]);
        ovf = 1'b0;
        unf = 1'b0;
        inx = 1'b0;
        if (ex == 255) begin
            if (mn != 0) return {3'b000, sgn, 15'h7E00};
            return {3'b000, sgn, 15'h7C00};
        end
        if (ex == 0) v = real'(mn) * pow2(-149);
        else         v = (8388608.0 + real'(mn)) * pow2(ex - 150);
        if (v < pow2(-14)) begin
            q = v * pow2(24);
            f = $rtoi(q);
            r = q - real'(f);
            inx = (r != 0.0);
            if (r > 0.5 || (r == 0.5 && (f % 2) == 1)) f++;
            mag = 15'(f);
            unf = inx;
        end else begin
            e = -14;
            while (e <= 15 && v >= pow2(e + 1)) e++;
            if (e > 15) begin
                mag = 15'h7C00;
                ovf = 1'b1;
                inx = 1'b1;
            end else begin
                q = v * pow2(10 - e);
                f = $rtoi(q);
                r = q - real'(f);
                inx = (r != 0.0);
                if (r > 0.5 || (r == 0.5 && (f % 2) == 1)) f++;
                if (f == 2048) begin
                    f = 1024;
                    e++;
                end
                if (e > 15) begin
                    mag = 15'h7C00;
                    ovf = 1'b1;
                end else begin
                    mag = 15'((e + 15) * 1024 + (f - 1024));
                end
            end
        end
        return {ovf, unf, inx, sgn, mag};
    endfunction

    function automatic logic [31:0] rand_fp32();
        int   sel;
        logic [31:0] x;
        sel = int'($urandom_range(0, 9));
        x   = $urandom();
        if (sel == 0) begin
            x[30:23] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
            if ($urandom_range(0, 1) == 0) x[22:0] = 23'd0;
        end else if (sel >= 2) begin
            x[30:23] = 8'($urandom_range(95, 145));
            if (sel == 2) x[11:0] = 12'h000;
            if (sel == 3) x[12:0] = 13'h1000;
        end
        return x;
    endfunction

    // Presents one word into an empty pipeline and captures the result.
    task automatic drive_one(input logic [31:0] x, output logic [15:0] d,
                             output logic [2:0] f, output logic early, output logic got);
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = x;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        early    = out_valid;
        @(posedge clk);
        #1;
        got = out_valid;
        d   = out_data;
        f   = {out_overflow, out_underflow, out_inexact};
    endtask

    task automatic drain();
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0000 ||
            {out_overflow, out_underflow, out_inexact} !== 3'b000) begin
            failures++;
            $display("FAIL reset_state: out_valid=%b out_data=%h flags=%b, required 0/0000/000",
                     out_valid, out_data, {out_overflow, out_underflow, out_inexact});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: in_ready=%b, required 1", in_ready);
        end
        $display("reset: out_valid=%b out_data=%h in_ready=%b", out_valid, out_data, in_ready);
    endtask

    task automatic run_table(input string tag, input logic [31:0] xs[], input logic [15:0] ds[],
                             input logic [2:0] fs[]);
        logic [15:0] d;
        logic [2:0]  f;
        logic        early, got;
        foreach (xs[i]) begin
            drive_one(xs[i], d, f, early, got);
            $display("%s: in=%h out=%h flags(o,u,i)=%b", tag, xs[i], d, f);
            checks++;
            if (early !== 1'b0 || got !== 1'b1) begin
                failures++;
                $display("FAIL %s_latency in=%h: valid after 1 edge=%b after 2 edges=%b, required 0 then 1",
                         tag, xs[i], early, got);
            end
            checks++;
            if (d !== ds[i]) begin
                failures++;
                $display("FAIL %s_data in=%h: got %h, required %h", tag, xs[i], d, ds[i]);
            end
            checks++;
            if (f !== fs[i]) begin
                failures++;
                $display("FAIL %s_flags in=%h: got %b, required %b", tag, xs[i], f, fs[i]);
            end
        end
    endtask

    task automatic test_basic();
        logic [31:0] xs[] = '{32'h3F800000, 32'hC0490FDB};
        logic [15:0] ds[] = '{16'h3C00, 16'hC248};
        logic [2:0]  fs[] = '{3'b000, 3'b001};
        run_table("basic", xs, ds, fs);
    endtask

    task automatic test_upper();
        logic [31:0] xs[] = '{32'h477FE000, 32'h477FF000, 32'h7F000000};
        logic [15:0] ds[] = '{16'h7BFF, 16'h7C00, 16'h7C00};
        logic [2:0]  fs[] = '{3'b000, 3'b101, 3'b101};
        run_table("upper", xs, ds, fs);
    endtask

    task automatic test_subnormal();
        logic [31:0] xs[] = '{32'h33800000, 32'h33000000, 32'h387FE000};
        logic [15:0] ds[] = '{16'h0001, 16'h0000, 16'h0400};
        logic [2:0]  fs[] = '{3'b000, 3'b011, 3'b011};
        run_table("subnormal", xs, ds, fs);
    endtask

    task automatic test_specials();
        logic [31:0] xs[] = '{32'hFFC00001, 32'hFF800000, 32'h80000000, 32'h00000001};
        logic [15:0] ds[] = '{16'hFE00, 16'hFC00, 16'h8000, 16'h0000};
        logic [2:0]  fs[] = '{3'b000, 3'b000, 3'b000, 3'b011};
        run_table("specials", xs, ds, fs);
    endtask

    task automatic test_back_to_back();
        logic [31:0] w[6];
        logic [18:0] obs, prev_obs, expv;
        int  sent = 0, recv = 0, held = 0, cyc = 0;
        bit  stall_prev = 1'b0, saw_drop = 1'b0;
        for (int i = 0; i < 6; i++) w[i] = rand_fp32();
        drain();
        prev_obs = '0;
        while (recv < 6 && cyc < 40) begin
            cyc++;
            @(negedge clk);
            in_valid  = (sent < 6);
            in_data   = w[(sent < 6) ? sent : 5];
            out_ready = !(cyc >= 3 && cyc <= 6);
            #1;
            obs = {out_overflow, out_underflow, out_inexact, out_data};
            checks++;
            if (in_ready !== !(held == 2 && !out_ready)) begin
                failures++;
                $display("FAIL b2b_in_ready cycle %0d: got %b, required %b", cyc, in_ready,
                         !(held == 2 && !out_ready));
            end
            if (!in_ready) saw_drop = 1'b1;
            if (stall_prev) begin
                checks++;
                if (out_valid !== 1'b1 || obs !== prev_obs) begin
                    failures++;
                    $display("FAIL b2b_stall_hold cycle %0d: valid=%b word=%h, required 1/%h",
                             cyc, out_valid, obs, prev_obs);
                end
            end
            if (out_valid && out_ready) begin
                expv = ref_conv(w[recv]);
                $display("b2b #%0d: in=%h out=%h flags=%b", recv, w[recv], out_data, obs[18:16]);
                checks++;
                if (obs !== expv) begin
                    failures++;
                    $display("FAIL b2b_result #%0d in=%h: got %h, required %h", recv, w[recv], obs, expv);
                end
                recv++;
                held--;
            end
            if (in_valid && in_ready) begin
                sent++;
                held++;
            end
            stall_prev = out_valid && !out_ready;
            prev_obs   = obs;
            @(posedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (recv != 6 || !saw_drop) begin
            failures++;
            $display("FAIL b2b_complete: received %0d words, in_ready dropped=%b, required 6 and 1",
                     recv, saw_drop);
        end
    endtask

    task automatic test_random();
        logic [31:0] in_q[$];
        logic [18:0] exp_q[$];
        logic [31:0] x, xin;
        logic [18:0] obs, prev_obs, expv;
        int  sent = 0, recv = 0, cyc = 0;
        bit  stall_prev = 1'b0;
        drain();
        x        = rand_fp32();
        prev_obs = '0;
        while (recv < 120 && cyc < 3000) begin
            cyc++;
            @(negedge clk);
            in_valid  = (sent < 120) && ($urandom_range(0, 9) < 7);
            in_data   = x;
            out_ready = ($urandom_range(0, 9) < 6);
            #1;
            obs = {out_overflow, out_underflow, out_inexact, out_data};
            checks++;
            if (in_ready !== !(exp_q.size() == 2 && !out_ready)) begin
                failures++;
                $display("FAIL rand_in_ready cycle %0d: got %b with %0d held", cyc, in_ready, exp_q.size());
            end
            if (stall_prev) begin
                checks++;
                if (out_valid !== 1'b1 || obs !== prev_obs) begin
                    failures++;
                    $display("FAIL rand_stall_hold cycle %0d: valid=%b word=%h, required 1/%h",
                             cyc, out_valid, obs, prev_obs);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rand_spurious cycle %0d: out word %h with nothing in flight", cyc, obs);
                end else begin
                    expv = exp_q.pop_front();
                    xin  = in_q.pop_front();
                    $display("rand #%0d: in=%h out=%h flags=%b", recv, xin, out_data, obs[18:16]);
                    if (obs !== expv) begin
                        failures++;
                        $display("FAIL rand_result #%0d in=%h: got %h, required %h", recv, xin, obs, expv);
                    end
                    recv++;
                end
            end
            if (in_valid && in_ready) begin
                in_q.push_back(x);
                exp_q.push_back(ref_conv(x));
                sent++;
                x = rand_fp32();
            end
            stall_prev = out_valid && !out_ready;
            prev_obs   = obs;
            @(posedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (recv != 120) begin
            failures++;
            $display("FAIL rand_timeout: received %0d of 120 words in %0d cycles", recv, cyc);
        end
    endtask

    task automatic test_async_reset();
        int seen = 0;
        drain();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h40000000;
        @(posedge clk);
        @(negedge clk);
        in_data = 32'h40400000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL areset_preload: out_valid=%b, required 1", out_valid);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0000) begin
            failures++;
            $display("FAIL areset_immediate: out_valid=%b out_data=%h, required 0/0000", out_valid, out_data);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL areset_stale: out_valid high on %0d cycles after release, required 0", seen);
        end
        $display("areset: stale outputs after release=%0d", seen);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_upper();
        test_subnormal();
        test_specials();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
